// File: rtl/song_reader_pkg.sv
// Shared widths and ROM word layout for the song reader.
// Anything that talks to the song ROM or note_player imports this package.
package song_reader_pkg;

  localparam int SONG_BITS     = 2;
  localparam int NOTE_IDX_BITS = 5;
  localparam int NOTE_W        = 6;
  localparam int DUR_W         = 6;

  localparam int ADDR_W = SONG_BITS + NOTE_IDX_BITS;
  localparam int ROM_W  = NOTE_W + DUR_W;

  typedef logic [SONG_BITS-1:0]     song_t;
  typedef logic [NOTE_IDX_BITS-1:0] note_idx_t;
  typedef logic [ADDR_W-1:0]        rom_addr_t;

  // ROM word: note in the upper field, duration in the lower field.
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
  } rom_word_t;

  // A zero duration terminates a song's note list.
  function automatic logic is_end_marker(rom_word_t w);
    return (w.duration == '0);
  endfunction

endpackage

// File: rtl/song_reader_if.sv
// Signal bundle between the mcu, the song ROM, note_player and song_reader.
// slave is the song_reader side; master is the environment that drives it.
interface song_reader_if;
  import song_reader_pkg::*;

  logic                  play;
  logic [SONG_BITS-1:0]  song;
  logic                  reset_player;
  logic                  note_done;
  logic [ADDR_W-1:0]     rom_addr;
  logic [ROM_W-1:0]      rom_data;
  logic [NOTE_W-1:0]     note;
  logic [DUR_W-1:0]      duration;
  logic                  new_note;
  logic                  song_done;

  modport slave (
    input  play, song, reset_player, note_done, rom_data,
    output rom_addr, note, duration, new_note, song_done
  );

  modport master (
    output play, song, reset_player, note_done, rom_data,
    input  rom_addr, note, duration, new_note, song_done
  );

endinterface

// File: rtl/song_reader.sv
// Walks the selected song's note list in an external 1-cycle ROM and hands
// one {note,duration} at a time to note_player; pulses song_done at the end.
module song_reader
  import song_reader_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  song_reader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    LATCH     = 2'd2,
    WAIT_NOTE = 2'd3
  } state_t;

  localparam note_idx_t IDX_LAST = '1;

  state_t    state, state_nxt;
  note_idx_t idx, idx_nxt;
  rom_word_t word;

  logic [NOTE_W-1:0] note_q;
  logic [DUR_W-1:0]  dur_q;
  logic              new_note_q, song_done_q;

  logic load, clear, new_note_nxt, song_done_nxt;

  assign word = rom_word_t'(bus.rom_data);

  // Address is only presented while fetching so song is sampled in FETCH alone.
  assign bus.rom_addr  = (state == FETCH) ? {bus.song, idx} : '0;
  assign bus.note      = note_q;
  assign bus.duration  = dur_q;
  assign bus.new_note  = new_note_q;
  assign bus.song_done = song_done_q;

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    load          = 1'b0;
    clear         = 1'b0;
    new_note_nxt  = 1'b0;
    song_done_nxt = 1'b0;
    if (bus.reset_player) begin
      // Restart wins over everything and is silent towards the mcu.
      state_nxt = IDLE;
      idx_nxt   = '0;
      clear     = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.play) state_nxt = FETCH;
        end
        FETCH: begin
          state_nxt = LATCH;
        end
        LATCH: begin
          if (is_end_marker(word)) begin
            song_done_nxt = 1'b1;
            idx_nxt       = '0;
            state_nxt     = IDLE;
          end else begin
            load         = 1'b1;
            new_note_nxt = 1'b1;
            state_nxt    = WAIT_NOTE;
          end
        end
        WAIT_NOTE: begin
          // note_done is taken even while paused so the handshake is never lost.
          if (bus.note_done) begin
            if (idx == IDX_LAST) begin
              song_done_nxt = 1'b1;
              idx_nxt       = '0;
              state_nxt     = IDLE;
            end else begin
              idx_nxt   = idx + note_idx_t'(1);
              state_nxt = bus.play ? FETCH : IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      note_q      <= '0;
      dur_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      new_note_q  <= new_note_nxt;
      song_done_q <= song_done_nxt;
      if (clear) begin
        note_q <= '0;
        dur_q  <= '0;
      end else if (load) begin
        note_q <= word.note;
        dur_q  <= word.duration;
      end
    end
  end

endmodule
